// File: rtl/registers.sv
// Integer register file: 2**ADDR_WIDTH registers, two combinational read ports, one
// synchronous write port. x0 has no storage and always reads as zero.
module registers #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  WR_EN,
   input  logic [ADDR_WIDTH-1:0] write_select,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] reg_1_select,
   input  logic [ADDR_WIDTH-1:0] reg_2_select,
   output logic [DATA_WIDTH-1:0] reg_1,
   output logic [DATA_WIDTH-1:0] reg_2
);

   localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

   // Index 0 is deliberately absent: x0 is a constant, not a register.
   logic [DATA_WIDTH-1:0] regs_q [1:NumRegs-1];
   logic [DATA_WIDTH-1:0] regs_d [1:NumRegs-1];

   always_comb begin
      for (int unsigned i = 1; i < NumRegs; i++) begin
         regs_d[i] = regs_q[i];
         if (WR_EN && (write_select == ADDR_WIDTH'(i))) begin
            regs_d[i] = data_in;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 1; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < NumRegs; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // No write bypass: reads always reflect the current array contents.
   always_comb begin
      reg_1 = '0;
      reg_2 = '0;
      for (int unsigned i = 1; i < NumRegs; i++) begin
         if (reg_1_select == ADDR_WIDTH'(i)) begin
            reg_1 = regs_q[i];
         end
         if (reg_2_select == ADDR_WIDTH'(i)) begin
            reg_2 = regs_q[i];
         end
      end
   end

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for registers: directed scenarios plus randomized traffic checked
// against a plain array model of the architectural register state.
`timescale 1ns/1ps
module tb_registers;

   logic        clock;
   logic        reset_n;
   logic        WR_EN;
   logic [4:0]  write_select;
   logic [31:0] data_in;
   logic [4:0]  reg_1_select;
   logic [4:0]  reg_2_select;
   logic [31:0] reg_1;
   logic [31:0] reg_2;

   logic [31:0] model [32];
   int checks = 0;
   int errors = 0;

   registers #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .WR_EN       (WR_EN),
      .write_select(write_select),
      .data_in     (data_in),
      .reg_1_select(reg_1_select),
      .reg_2_select(reg_2_select),
      .reg_1       (reg_1),
      .reg_2       (reg_2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
         $error("%s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference write rule: x0 is never writable, WR_EN gates everything.
   task automatic model_edge(input logic we, input logic [4:0] sel, input logic [31:0] d);
      if (reset_n && we && sel != 5'd0) model[sel] = d;
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge(WR_EN, write_select, data_in);
      #1;
   endtask

   task automatic check_reads(input string tag);
      chk({tag, "_r1"}, reg_1, model[reg_1_select]);
      chk({tag, "_r2"}, reg_2, model[reg_2_select]);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   initial begin
      model_clear();
      reset_n = 1'b0;
      WR_EN = 1'b0;
      write_select = '0;
      data_in = '0;
      reg_1_select = '0;
      reg_2_select = '0;
      #12;
      reset_n = 1'b1;
      tick();  // first edge after release carries no write

      // Reset sweep
      for (int i = 0; i < 32; i++) begin
         reg_1_select = 5'(i);
         reg_2_select = 5'(31 - i);
         #1;
         chk("reset_sweep_r1", reg_1, 32'h0);
         chk("reset_sweep_r2", reg_2, 32'h0);
      end

      // Basic write/read
      WR_EN = 1'b1; write_select = 5'd16; data_in = 32'hAAAA_AAAA;
      tick();
      write_select = 5'd17; data_in = 32'hBBBB_BBBB;
      tick();
      WR_EN = 1'b0;
      reg_1_select = 5'd16; reg_2_select = 5'd17; #1;
      chk("basic_x16", reg_1, 32'hAAAA_AAAA);
      chk("basic_x17", reg_2, 32'hBBBB_BBBB);

      // x0 protection
      WR_EN = 1'b1; write_select = 5'd0; data_in = 32'hCCCC_CCCC;
      tick();
      WR_EN = 1'b0;
      reg_1_select = 5'd0; reg_2_select = 5'd1; #1;
      chk("x0_reads_zero", reg_1, 32'h0);
      chk("x0_x1_untouched", reg_2, 32'h0);
      reg_1_select = 5'd16; #1;
      chk("x0_x16_untouched", reg_1, 32'hAAAA_AAAA);

      // Write-enable gating
      WR_EN = 1'b0; write_select = 5'd16; data_in = 32'h1234_5678;
      tick();
      reg_1_select = 5'd16; #1;
      chk("wr_en_gate_x16", reg_1, 32'hAAAA_AAAA);

      // Read during write, same index on both ports
      reg_1_select = 5'd17; reg_2_select = 5'd17;
      WR_EN = 1'b1; write_select = 5'd17; data_in = 32'hDEAD_BEEF; #1;
      chk("rdw_pre_r1", reg_1, 32'hBBBB_BBBB);
      chk("rdw_pre_r2", reg_2, 32'hBBBB_BBBB);
      tick();
      WR_EN = 1'b0;
      chk("rdw_post_r1", reg_1, 32'hDEAD_BEEF);
      chk("rdw_post_r2", reg_2, 32'hDEAD_BEEF);

      // Randomized traffic, checked both before and after each edge
      for (int n = 0; n < 300; n++) begin
         WR_EN = 1'($urandom_range(0, 3) != 0);
         write_select = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         data_in = $urandom;
         reg_1_select = 5'($urandom);
         reg_2_select = ($urandom_range(0, 3) == 0) ? write_select : 5'($urandom);
         #1;
         check_reads("rand_pre");
         tick();
         check_reads("rand_post");
      end

      // Fill x1..x31 with their index, then reset between edges
      WR_EN = 1'b1;
      for (int i = 1; i < 32; i++) begin
         write_select = 5'(i); data_in = 32'(i);
         tick();
      end
      WR_EN = 1'b0;
      for (int i = 0; i < 32; i++) begin
         reg_1_select = 5'(i); reg_2_select = 5'(i); #0.05;
         chk("fill_r1", reg_1, 32'(i));
         chk("fill_r2", reg_2, 32'(i));
      end
      @(posedge clock); #2;
      reset_n = 1'b0;
      model_clear();
      for (int i = 0; i < 32; i++) begin
         reg_1_select = 5'(i); reg_2_select = 5'(31 - i); #0.05;
         chk("async_rst_r1", reg_1, 32'h0);
         chk("async_rst_r2", reg_2, 32'h0);
      end

      // Writes while held in reset are lost
      WR_EN = 1'b1; write_select = 5'd5; data_in = 32'h5555_5555;
      tick();
      reg_1_select = 5'd5; #1;
      chk("write_in_reset", reg_1, 32'h0);
      WR_EN = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      reg_1_select = 5'd5; reg_2_select = 5'd31; #1;
      chk("post_reset_x5", reg_1, 32'h0);
      chk("post_reset_x31", reg_2, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
